// File: rtl/boot_loader_ctrl_if.sv
// rtl/boot_loader_ctrl_if.sv - byte-stream input and CRAM port-B write bus of the boot loader
interface boot_loader_ctrl_if #(
    parameter int ADDR_W = 14
) ();
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              cram_we;
    logic [ADDR_W-1:0] cram_addr;
    logic [31:0]       cram_data;

    // master: serial link source and CRAM observer
    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  cram_we,
        input  cram_addr,
        input  cram_data
    );

    // slave: the boot loader controller itself
    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output cram_we,
        output cram_addr,
        output cram_data
    );
endinterface

// File: rtl/boot_loader_ctrl.sv
// rtl/boot_loader_ctrl.sv - loads a length-prefixed little-endian word image from a byte link into CRAM
module boot_loader_ctrl #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    boot_loader_ctrl_if.slave   bus,
    output logic                boot,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     word_cnt
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam int               TO_W       = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam longint unsigned  CRAM_WORDS = 64'd1 << ADDR_W;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       len_q, len_d;
    logic [31:0]       shift_q, shift_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;

    logic              ready;
    logic              accept;
    logic [15:0]       len_full;
    logic [31:0]       word_full;
    logic [ADDR_W:0]   cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            shift_q <= '0;
            to_q    <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            shift_q <= shift_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        shift_d   = shift_q;
        to_d      = to_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;

        ready     = (state_q == S_LEN) || (state_q == S_DATA);
        accept    = ready && bus.byte_valid;
        len_full  = {bus.byte_in, len_q[7:0]};
        // bytes enter at the top so the first byte of a word ends up in bits 7:0
        word_full = {bus.byte_in, shift_q[31:8]};
        cnt_next  = cnt_q + 1'b1;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    cnt_d   = '0;
                    idx_d   = '0;
                    to_d    = '0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    to_d = '0;
                    if (idx_q == 2'd0) begin
                        len_d[7:0] = bus.byte_in;
                        idx_d      = 2'd1;
                    end else begin
                        len_d = len_full;
                        idx_d = 2'd0;
                        if (len_full == 16'd0) begin
                            state_d = S_DONE;
                        end else if (64'(len_full) > CRAM_WORDS) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_DATA: begin
                if (accept) begin
                    to_d    = '0;
                    shift_d = word_full;
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                        addr_d  = cnt_q[ADDR_W-1:0];
                        data_d  = word_full;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_WRITE: begin
                cnt_d = cnt_next;
                if (32'(cnt_next) == 32'(len_q)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.byte_ready = ready;
    assign bus.cram_we    = (state_q == S_WRITE);
    assign bus.cram_addr  = addr_q;
    assign bus.cram_data  = data_q;
    // the core stays held in boot mode unless a load has completed cleanly
    assign boot           = (state_q != S_DONE);
    assign done           = (state_q == S_DONE);
    assign err            = (state_q == S_ERR);
    assign word_cnt       = cnt_q;
endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb/tb_boot_loader_ctrl.sv - randomized self-checking bench for boot_loader_ctrl
module tb_boot_loader_ctrl;
    localparam int ADDR_W  = 14;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              boot, done, err;
    logic [ADDR_W:0]   word_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0]       obs_data[$];
    logic [ADDR_W-1:0] obs_addr[$];

    boot_loader_ctrl_if #(.ADDR_W(ADDR_W)) bif ();

    boot_loader_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bif.slave),
        .boot     (boot),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bif.cram_we === 1'b1) begin
            obs_data.push_back(bif.cram_data);
            obs_addr.push_back(bif.cram_addr);
        end
        if (rst_n) begin
            vectors++;
            if ((done & err) !== 1'b0) begin
                miscompares++;
                $display("FAIL done_err_exclusive: done=%b err=%b, required not both 1", done, err);
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bif.byte_in    = b;
        bif.byte_valid = 1'b1;
        n = 0;
        while (bif.byte_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            vectors++;
            miscompares++;
            $display("FAIL send_byte_stall: byte %h never accepted within 40 cycles", b);
        end
        @(posedge clk);
        #1;
        bif.byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bif.byte_in = 8'h00;
        bif.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({boot, bif.byte_ready, bif.cram_we, done, err} !== 5'b10000 || bif.cram_addr !== '0 ||
            bif.cram_data !== 32'h0 || word_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_values: boot=%b rdy=%b we=%b done=%b err=%b addr=%h data=%h cnt=%0d, required 1 0 0 0 0 0 0 0",
                     boot, bif.byte_ready, bif.cram_we, done, err, bif.cram_addr, bif.cram_data, word_cnt);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] bytes [10];
        bytes = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        obs_data.delete();
        obs_addr.delete();
        do_start();
        for (int i = 0; i < 10; i++) send_byte(bytes[i], 0);
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_data.size() != 2) begin
            miscompares++;
            $display("FAIL basic_write_count: got %0d, required 2", obs_data.size());
        end else begin
            vectors++;
            if (obs_addr[0] !== 14'd0 || obs_data[0] !== 32'h12345678 || obs_addr[1] !== 14'd1 || obs_data[1] !== 32'hDEADBEEF) begin
                miscompares++;
                $display("FAIL basic_writes: got %h=%h %h=%h, required 0=12345678 1=deadbeef",
                         obs_addr[0], obs_data[0], obs_addr[1], obs_data[1]);
            end
        end
        vectors++;
        if (done !== 1'b1 || boot !== 1'b0 || err !== 1'b0 || word_cnt !== 15'd2) begin
            miscompares++;
            $display("FAIL basic_status: done=%b boot=%b err=%b cnt=%0d, required 1 0 0 2", done, boot, err, word_cnt);
        end
        vectors++;
        if (bif.cram_addr !== 14'd1 || bif.cram_data !== 32'hDEADBEEF || bif.byte_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_hold: addr=%h data=%h rdy=%b, required 1 deadbeef 0", bif.cram_addr, bif.cram_data, bif.byte_ready);
        end
    endtask

    task automatic test_zero_len();
        obs_data.delete();
        obs_addr.delete();
        do_start();
        vectors++;
        if (done !== 1'b0 || boot !== 1'b1 || word_cnt !== '0) begin
            miscompares++;
            $display("FAIL restart_clears: done=%b boot=%b cnt=%0d, required 0 1 0", done, boot, word_cnt);
        end
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        repeat (3) @(negedge clk);
        vectors++;
        if (done !== 1'b1 || err !== 1'b0 || word_cnt !== '0 || obs_data.size() != 0) begin
            miscompares++;
            $display("FAIL zero_len: done=%b err=%b cnt=%0d writes=%0d, required 1 0 0 0", done, err, word_cnt, obs_data.size());
        end
    endtask

    task automatic test_too_long();
        obs_data.delete();
        obs_addr.delete();
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h40, 0);
        repeat (2) @(negedge clk);
        vectors++;
        if (err !== 1'b1 || boot !== 1'b1 || done !== 1'b0 || obs_data.size() != 0) begin
            miscompares++;
            $display("FAIL too_long: err=%b boot=%b done=%b writes=%0d, required 1 1 0 0", err, boot, done, obs_data.size());
        end
        // exactly 2^ADDR_W words is legal and must enter the data phase
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        @(negedge clk);
        vectors++;
        if (err !== 1'b0 || bif.byte_ready !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL full_len_accepted: err=%b rdy=%b done=%b, required 0 1 0", err, bif.byte_ready, done);
        end
        repeat (TIMEOUT + 2) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [7:0] bytes [6];
        bytes = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        obs_data.delete();
        obs_addr.delete();
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        vectors++;
        if (err !== 1'b0 || bif.byte_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early: err=%b rdy=%b after %0d idle cycles, required 0 1", err, bif.byte_ready, TIMEOUT - 1);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (err !== 1'b1 || boot !== 1'b1 || obs_data.size() != 0) begin
            miscompares++;
            $display("FAIL timeout_err: err=%b boot=%b writes=%0d, required 1 1 0", err, boot, obs_data.size());
        end
        do_start();
        for (int i = 0; i < 6; i++) send_byte(bytes[i], 0);
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_data.size() != 1 || done !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_recover: writes=%0d done=%b err=%b, required 1 1 0", obs_data.size(), done, err);
        end else begin
            vectors++;
            if (obs_addr[0] !== 14'd0 || obs_data[0] !== 32'h04030201) begin
                miscompares++;
                $display("FAIL timeout_recover_word: got %h=%h, required 0=04030201", obs_addr[0], obs_data[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bytes [14];
        logic [31:0] words [3];
        bit          acc;
        int          idx, cyc;
        for (int w = 0; w < 3; w++) words[w] = $urandom;
        bytes[0] = 8'h03;
        bytes[1] = 8'h00;
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < 4; k++) bytes[2 + 4*w + k] = words[w][8*k +: 8];
        obs_data.delete();
        obs_addr.delete();
        @(negedge clk);
        bif.byte_in    = bytes[0];
        bif.byte_valid = 1'b1;
        do_start();
        idx = 0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            vectors++;
            if (bif.byte_ready !== ~bif.cram_we) begin
                miscompares++;
                $display("FAIL stream_ready: rdy=%b we=%b at cycle %0d, required rdy = !we", bif.byte_ready, bif.cram_we, cyc);
            end
            acc = (bif.byte_ready === 1'b1);
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
            if (idx < 14) bif.byte_in = bytes[idx];
            else bif.byte_valid = 1'b0;
            cyc++;
        end
        bif.byte_valid = 1'b0;
        vectors++;
        if (done !== 1'b1 || idx != 14 || obs_data.size() != 3) begin
            miscompares++;
            $display("FAIL stream_done: done=%b bytes=%0d writes=%0d, required 1 14 3", done, idx, obs_data.size());
        end else begin
            for (int w = 0; w < 3; w++) begin
                vectors++;
                if (obs_addr[w] !== 14'(w) || obs_data[w] !== words[w]) begin
                    miscompares++;
                    $display("FAIL stream_word%0d: got %h=%h, required %h=%h", w, obs_addr[w], obs_data[w], 14'(w), words[w]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int iter = 0; iter < 8; iter++) begin
            int          n;
            logic [31:0] words [$];
            logic [7:0]  stream [$];
            n = $urandom_range(1, 6);
            words.delete();
            stream.delete();
            for (int w = 0; w < n; w++) words.push_back($urandom);
            stream.push_back(8'(n));
            stream.push_back(8'h00);
            foreach (words[w])
                for (int k = 0; k < 4; k++) stream.push_back(words[w][8*k +: 8]);
            obs_data.delete();
            obs_addr.delete();
            do_start();
            foreach (stream[i]) send_byte(stream[i], $urandom_range(0, 3));
            repeat (3) @(negedge clk);
            vectors++;
            if (done !== 1'b1 || err !== 1'b0 || boot !== 1'b0 || word_cnt !== 15'(n) || obs_data.size() != n) begin
                miscompares++;
                $display("FAIL random%0d_status: done=%b err=%b boot=%b cnt=%0d writes=%0d, required 1 0 0 %0d %0d",
                         iter, done, err, boot, word_cnt, obs_data.size(), n, n);
            end else begin
                for (int w = 0; w < n; w++) begin
                    vectors++;
                    if (obs_addr[w] !== 14'(w) || obs_data[w] !== words[w]) begin
                        miscompares++;
                        $display("FAIL random%0d_word%0d: got %h=%h, required %h=%h", iter, w, obs_addr[w], obs_data[w], 14'(w), words[w]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bytes [4];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        obs_data.delete();
        obs_addr.delete();
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hC1, 0);
        send_byte(8'hC2, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({boot, bif.byte_ready, bif.cram_we, done, err} !== 5'b10000 || bif.cram_addr !== '0 ||
            bif.cram_data !== 32'h0 || word_cnt !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_values: boot=%b rdy=%b we=%b done=%b err=%b addr=%h data=%h cnt=%0d, required 1 0 0 0 0 0 0 0",
                     boot, bif.byte_ready, bif.cram_we, done, err, bif.cram_addr, bif.cram_data, word_cnt);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (obs_data.size() != 0 || bif.byte_ready !== 1'b0 || boot !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_idle: writes=%0d rdy=%b boot=%b, required 0 0 1", obs_data.size(), bif.byte_ready, boot);
        end
        // a start pulse between the two length bytes must not restart the session
        do_start();
        send_byte(8'h01, 0);
        do_start();
        send_byte(8'h00, 0);
        for (int i = 0; i < 4; i++) send_byte(bytes[i], 0);
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_data.size() != 1 || done !== 1'b1 || word_cnt !== 15'd1) begin
            miscompares++;
            $display("FAIL start_in_len: writes=%0d done=%b cnt=%0d, required 1 1 1", obs_data.size(), done, word_cnt);
        end else begin
            vectors++;
            if (obs_addr[0] !== 14'd0 || obs_data[0] !== 32'h44332211) begin
                miscompares++;
                $display("FAIL start_in_len_word: got %h=%h, required 0=44332211", obs_addr[0], obs_data[0]);
            end
        end
    endtask

    initial begin
        bif.byte_in    = 8'h00;
        bif.byte_valid = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_too_long();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/boot_loader_ctrl.md
BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 Parameter ADDR_W, default 14, CRAM word-address width.
REQ-002 Parameter TIMEOUT, default 1000000, max idle cycles between accepted bytes before error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a load session.
REQ-006 byte_in  input  8  serial-link byte.
REQ-007 byte_valid  input  1  byte_in valid.
REQ-008 byte_ready  output  1  controller accepts byte; transfer when byte_valid & byte_ready.
REQ-009 boot  output  1  CRAM port-B ownership; high holds core in boot mode.
REQ-010 cram_we  output  1  CRAM port-B write strobe.
REQ-011 cram_addr  output  ADDR_W  CRAM port-B word address.
REQ-012 cram_data  output  32  CRAM port-B write data.
REQ-013 done  output  1  load completed successfully.
REQ-014 err  output  1  load aborted.
REQ-015 word_cnt  output  ADDR_W+1  words written this session.

Function
REQ-016 States: IDLE, LEN, DATA, WRITE, DONE, ERR.
REQ-017 IDLE/DONE/ERR: start -> LEN next cycle; clears word_cnt, done, err, timeout counter, byte index; sets boot=1.
REQ-018 start in LEN/DATA/WRITE is ignored.
REQ-019 byte_ready=1 only in LEN and DATA; 0 in all other states.
REQ-020 LEN: two accepted bytes form 16-bit word count N, little-endian (first byte = N[7:0]).
REQ-021 After 2nd LEN byte: N==0 -> DONE; N > 2^ADDR_W -> ERR; else -> DATA.
REQ-022 DATA: four accepted bytes form one word, little-endian (first byte = bits 7:0); after 4th byte -> WRITE next cycle.
REQ-023 WRITE lasts exactly one cycle: cram_we=1, cram_addr=word_cnt[ADDR_W-1:0], cram_data=assembled word.
REQ-024 Leaving WRITE: word_cnt increments; if new word_cnt==N -> DONE, else -> DATA.
REQ-025 cram_we=0 in every state except WRITE; cram_addr/cram_data hold last values otherwise.
REQ-026 Byte latency: 4th byte accepted at cycle t -> cram_we high in cycle t+1; next byte acceptable in cycle t+2.
REQ-027 Timeout counter counts cycles in LEN/DATA with no accepted byte; reaching TIMEOUT -> ERR; any accepted byte zeroes it.
REQ-028 DONE: boot=0, done=1, held until next start.
REQ-029 ERR: boot=1 (core stays held), err=1, held until next start; partial words discarded.
REQ-030 done and err never both 1.
REQ-031 word_cnt width allows value 2^ADDR_W without overflow; N==2^ADDR_W fills CRAM exactly.

Reset
REQ-032 rst_n low, any state incl. mid-session: state=IDLE, boot=1, byte_ready=0, cram_we=0, cram_addr=0, cram_data=0, done=0, err=0, word_cnt=0, counters=0.
REQ-033 Reset mid-session leaves already-written CRAM words untouched; no write strobe during or after reset until a new session reaches WRITE.

Verification
REQ-034 TIMEOUT=16: start; bytes 02 00, 78 56 34 12, EF BE AD DE -> cram writes addr0=0x12345678, addr1=0xDEADBEEF; done=1, boot=0, word_cnt=2.
REQ-035 start; bytes 00 00 -> DONE with no cram_we pulse, word_cnt=0.
REQ-036 ADDR_W=14: start; bytes 01 40 (N=16385) -> err=1, boot=1, no cram_we.
REQ-037 TIMEOUT=16: start; 01 00 AA BB then 16 idle cycles -> err=1, no cram_we; new start then 01 00 01 02 03 04 -> addr0=0x04030201, done=1.
REQ-038 byte_valid held high continuously with N=3: byte_ready low exactly in each WRITE cycle, three writes to addr 0,1,2, no byte lost or duplicated.
REQ-039 rst_n asserted during DATA after 2 of 4 bytes -> all outputs at reset values immediately; start pulse in LEN ignored.
